// File: rtl/booth_pkg.sv
// Shared Booth radix-4 definitions: digit and FSM state enums plus the triplet decoder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package booth_pkg;

   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } booth_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } booth_state_t;

   // Map a multiplier triplet {m[i+1], m[i], m[i-1]} to its radix-4 Booth digit.
   function automatic booth_digit_t booth_decode(input logic [2:0] trip);
      booth_digit_t d;
      case (trip)
         3'b001, 3'b010: d = POS1;
         3'b011:         d = POS2;
         3'b100:         d = NEG2;
         3'b101, 3'b110: d = NEG1;
         default:        d = ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Turns one Booth triplet and the current multiplicand into the signed addend for the accumulator.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module booth_r4_digit
   import booth_pkg::*;
#(
   parameter int W = 68
) (
   input  logic [2:0]   triplet,
   input  logic [W-1:0] mcand,
   output logic [W-1:0] addend
);

   logic [W-1:0] one;
   logic [W-1:0] mcand_x2;

   assign one      = {{(W-1){1'b0}}, 1'b1};
   assign mcand_x2 = mcand << 1;

   // Select 0, +M, +2M, -M or -2M; negation is two's complement modulo 2^W.
   always_comb begin
      addend = '0;
      case (booth_decode(triplet))
         POS1:    addend = mcand;
         POS2:    addend = mcand_x2;
         NEG1:    addend = (~mcand) + one;
         NEG2:    addend = (~mcand_x2) + one;
         default: addend = '0;
      endcase
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, signed or unsigned per operation.
// Latency: done pulses WIDTH/2+2 cycles after start is taken (data dependent with BOOTH_MUL_EARLY_EXIT_EN).
// Backpressure: start is ignored while busy; product holds until the next done.
module booth_mul_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   // Two guard bits make unsigned operands with the top bit set exact.
   localparam int E  = WIDTH + 2;
   localparam int PW = 2 * E;
   localparam int N  = E / 2;
   localparam int CW = $clog2(N + 1);

   booth_state_t  state;
   logic [PW-1:0] mcand;
   logic [PW-1:0] acc;
   logic [E:0]    mplier;
   logic [CW-1:0] cnt;

   logic [E-1:0]  ext_a;
   logic [E-1:0]  ext_b;
   logic [PW-1:0] addend;
   logic [PW-1:0] acc_sum;
   logic [E:0]    mplier_nxt;
   logic          last_digit;

   assign ext_a = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
   assign ext_b = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

   booth_r4_digit #(
      .W (PW)
   ) u_digit (
      .triplet (mplier[2:0]),
      .mcand   (mcand),
      .addend  (addend)
   );

   assign acc_sum    = acc + addend;
   assign mplier_nxt = {{2{mplier[E]}}, mplier[E:2]};

`ifdef BOOTH_MUL_EARLY_EXIT_EN
   // Once the remaining multiplier is all zeros or all ones every later digit is zero.
   assign last_digit = (cnt == CW'(1)) || (&mplier_nxt) || (~|mplier_nxt);
`else
   assign last_digit = (cnt == CW'(1));
`endif

   // Control FSM with datapath registers; outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {{E{ext_a[E-1]}}, ext_a};
                  mplier <= {ext_b, 1'b0};
                  acc    <= '0;
                  cnt    <= CW'(N);
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_sum;
               mcand  <= mcand << 2;
               mplier <= mplier_nxt;
               cnt    <= cnt - CW'(1);
               if (last_digit) begin
                  state <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b1;
               product <= acc[2*WIDTH-1:0];
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
